// File: rtl/bus_transfer_scheduler.sv
// bus_transfer_scheduler
// ---------------------------------------------------------------------------
// Purpose:
//   Queues (source, destination) register-transfer commands from the control
//   unit and issues at most one per cycle onto the shared CPU bus. Each issued
//   transfer drives the bus-mux select and a one-hot destination load enable
//   that is high for exactly one cycle.
//
// Handshake (command side):
//   cmd_valid/cmd_ready are strict valid/ready. A command transfers at a
//   rising clock edge where both are high. cmd_ready is high whenever the FIFO
//   is not full and does not depend on cmd_valid. While cmd_valid is high and
//   cmd_ready is low, the source keeps the command stable.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  FIFO can accept (not full)
//   cmd_src    in   bus source code (valid codes 0..NUM_SRC-1)
//   cmd_dst    in   destination code, decoded one-hot onto dst_en
//   hold       in   stall; no issue while high (pushes still accepted)
//   bus_sel    out  bus-mux select; holds its last value when idle
//   dst_en     out  one-hot destination load enable, one cycle per transfer
//   xfer_done  out  pulses together with each non-zero dst_en
//   err_src    out  one-cycle pulse when a popped command has an invalid source
//   busy       out  FIFO non-empty or a transfer on the bus
//   level      out  FIFO occupancy
//
// Build option:
//   BUS_XFER_BYPASS_EN - when defined, a command accepted while the FIFO is
//   empty and hold is low goes straight to the output registers at the same
//   edge (1-edge latency, level stays 0).
// ---------------------------------------------------------------------------
module bus_transfer_scheduler #(
  parameter int DEPTH   = 4,
  parameter int SEL_W   = 5,
  parameter int NUM_SRC = 24
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [SEL_W-1:0]        cmd_src,
  input  logic [SEL_W-1:0]        cmd_dst,
  input  logic                    hold,
  output logic [SEL_W-1:0]        bus_sel,
  output logic [(2**SEL_W)-1:0]   dst_en,
  output logic                    xfer_done,
  output logic                    err_src,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = 2 ** SEL_W;
  localparam logic [AW:0]    DepthVal  = (AW + 1)'(DEPTH);
  localparam logic [SEL_W:0] NumSrcVal = (SEL_W + 1)'(NUM_SRC);

  logic [SEL_W-1:0] srcMem [DEPTH];
  logic [SEL_W-1:0] dstMem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;

  logic             fifoEmpty;
  logic             fifoFull;
  logic             accept;
  logic             bypass;
  logic             doPush;
  logic             doPop;
  logic             issueValid;
  logic [SEL_W-1:0] issueSrc;
  logic [SEL_W-1:0] issueDst;
  logic             srcOk;
  logic [DW-1:0]    dstOneHot;

  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == DepthVal);
  assign cmd_ready = !fifoFull;
  assign accept    = cmd_valid && !fifoFull;

`ifdef BUS_XFER_BYPASS_EN
  // An empty, unstalled queue lets a new command skip straight to issue.
  assign bypass = accept && fifoEmpty && !hold;
`else
  assign bypass = 1'b0;
`endif

  assign doPush = accept && !bypass;
  assign doPop  = !fifoEmpty && !hold;

  // The head of the FIFO takes priority; bypass only happens when it is empty.
  assign issueValid = doPop || bypass;
  assign issueSrc   = doPop ? srcMem[rdPtr] : cmd_src;
  assign issueDst   = doPop ? dstMem[rdPtr] : cmd_dst;
  assign srcOk      = ({1'b0, issueSrc} < NumSrcVal);
  assign dstOneHot  = DW'(1) << issueDst;

  // Storage needs no reset: entries are only read when count says they exist.
  always_ff @(posedge clock) begin
    if (doPush) begin
      srcMem[wrPtr] <= cmd_src;
      dstMem[wrPtr] <= cmd_dst;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output registers. bus_sel only moves on a valid issue so the bus mux
  // never glitches through an idle or rejected cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_sel   <= '0;
      dst_en    <= '0;
      xfer_done <= 1'b0;
      err_src   <= 1'b0;
    end else if (issueValid && srcOk) begin
      bus_sel   <= issueSrc;
      dst_en    <= dstOneHot;
      xfer_done <= 1'b1;
      err_src   <= 1'b0;
    end else begin
      dst_en    <= '0;
      xfer_done <= 1'b0;
      err_src   <= issueValid;
    end
  end

  assign busy  = !fifoEmpty || (dst_en != '0);
  assign level = count;

endmodule

// File: tb/tb_bus_transfer_scheduler.sv
// tb_bus_transfer_scheduler
// ---------------------------------------------------------------------------
// Directed bench for bus_transfer_scheduler (default parameters). Inputs are
// changed 1 time unit after each rising edge; outputs are checked at the same
// point, so every check sees the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_bus_transfer_scheduler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_src = '0;
  logic [4:0]  cmd_dst = '0;
  logic        hold = 1'b0;
  logic [4:0]  bus_sel;
  logic [31:0] dst_en;
  logic        xfer_done;
  logic        err_src;
  logic        busy;
  logic [2:0]  level;

  int errors = 0;
  int checks = 0;

  bus_transfer_scheduler dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .hold      (hold),
    .bus_sel   (bus_sel),
    .dst_en    (dst_en),
    .xfer_done (xfer_done),
    .err_src   (err_src),
    .busy      (busy),
    .level     (level)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++; if (bus_sel !== 5'd0) begin errors++; $display("FAIL reset_bus_sel: got %0d expected 0", bus_sel); end
    checks++; if (dst_en !== 32'd0) begin errors++; $display("FAIL reset_dst_en: got %h expected 0", dst_en); end
    checks++; if (xfer_done !== 1'b0) begin errors++; $display("FAIL reset_xfer_done: got %b expected 0", xfer_done); end
    checks++; if (err_src !== 1'b0) begin errors++; $display("FAIL reset_err_src: got %b expected 0", err_src); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    cmd_src = 5'd5; cmd_dst = 5'd21; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level_queued: got %0d expected 1", level); end
    checks++; if (dst_en !== 32'd0) begin errors++; $display("FAIL single_no_early_issue: got %h expected 0", dst_en); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_queued: got %b expected 1", busy); end
    tick();
    checks++; if (bus_sel !== 5'd5) begin errors++; $display("FAIL single_bus_sel: got %0d expected 5", bus_sel); end
    checks++; if (dst_en !== 32'h0020_0000) begin errors++; $display("FAIL single_dst_en: got %h expected 00200000", dst_en); end
    checks++; if (xfer_done !== 1'b1) begin errors++; $display("FAIL single_xfer_done: got %b expected 1", xfer_done); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_level_after: got %0d expected 0", level); end
    tick();
    checks++; if (dst_en !== 32'd0) begin errors++; $display("FAIL single_dst_en_clear: got %h expected 0", dst_en); end
    checks++; if (xfer_done !== 1'b0) begin errors++; $display("FAIL single_xfer_done_clear: got %b expected 0", xfer_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
    checks++; if (bus_sel !== 5'd5) begin errors++; $display("FAIL single_bus_sel_hold: got %0d expected 5", bus_sel); end
  endtask

  // Commands (src=i+1, dst=i+8) for i=0..3 queue under hold, then drain.
  task automatic test_full_hold();
    logic [31:0] expEn;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_src = 5'(i + 1); cmd_dst = 5'(i + 8); cmd_valid = 1'b1;
      tick();
      checks++; if (level !== 3'(i + 1)) begin errors++; $display("FAIL full_fill_level: got %0d expected %0d", level, i + 1); end
    end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_cmd_ready: got %b expected 0", cmd_ready); end
    cmd_src = 5'd9; cmd_dst = 5'd30;
    tick();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_reject_level: got %0d expected 4", level); end
    checks++; if (dst_en !== 32'd0) begin errors++; $display("FAIL full_hold_no_issue: got %h expected 0", dst_en); end
    cmd_valid = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      expEn = 32'd1 << (i + 8);
      checks++; if (bus_sel !== 5'(i + 1)) begin errors++; $display("FAIL full_drain_bus_sel: got %0d expected %0d", bus_sel, i + 1); end
      checks++; if (dst_en !== expEn) begin errors++; $display("FAIL full_drain_dst_en: got %h expected %h", dst_en, expEn); end
      checks++; if (xfer_done !== 1'b1) begin errors++; $display("FAIL full_drain_xfer_done: got %b expected 1", xfer_done); end
      checks++; if (level !== 3'(3 - i)) begin errors++; $display("FAIL full_drain_level: got %0d expected %0d", level, 3 - i); end
    end
    tick();
    checks++; if (dst_en !== 32'd0) begin errors++; $display("FAIL full_end_dst_en: got %h expected 0", dst_en); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_end_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_end_busy: got %b expected 0", busy); end
  endtask

  // Last valid bus_sel coming in is 4 (from test_full_hold).
  task automatic test_err_src();
    cmd_src = 5'd25; cmd_dst = 5'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++; if (err_src !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b expected 1", err_src); end
    checks++; if (dst_en !== 32'd0) begin errors++; $display("FAIL err_dst_en: got %h expected 0", dst_en); end
    checks++; if (xfer_done !== 1'b0) begin errors++; $display("FAIL err_xfer_done: got %b expected 0", xfer_done); end
    checks++; if (bus_sel !== 5'd4) begin errors++; $display("FAIL err_bus_sel_hold: got %0d expected 4", bus_sel); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL err_discarded: got %0d expected 0", level); end
    cmd_src = 5'd7; cmd_dst = 5'd9; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++; if (err_src !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b expected 0", err_src); end
    tick();
    checks++; if (bus_sel !== 5'd7) begin errors++; $display("FAIL err_next_bus_sel: got %0d expected 7", bus_sel); end
    checks++; if (dst_en !== 32'h0000_0200) begin errors++; $display("FAIL err_next_dst_en: got %h expected 00000200", dst_en); end
    checks++; if (xfer_done !== 1'b1) begin errors++; $display("FAIL err_next_xfer_done: got %b expected 1", xfer_done); end
    tick();
  endtask

  // Ten commands: src = j+10, dst = (7*j+1) mod 32. Two are preloaded under
  // hold, then push and pop overlap every cycle at level 2.
  task automatic test_stream();
    logic [4:0]  srcTab [10];
    logic [4:0]  dstTab [10];
    logic [31:0] expEn;
    for (int j = 0; j < 10; j++) begin
      srcTab[j] = 5'(j + 10);
      dstTab[j] = 5'((7 * j + 1) % 32);
    end
    hold = 1'b1;
    for (int j = 0; j < 2; j++) begin
      cmd_src = srcTab[j]; cmd_dst = dstTab[j]; cmd_valid = 1'b1;
      tick();
    end
    hold = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (j < 8) begin
        cmd_src = srcTab[j + 2]; cmd_dst = dstTab[j + 2]; cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      expEn = 32'd1 << dstTab[j];
      checks++; if (bus_sel !== srcTab[j]) begin errors++; $display("FAIL stream_bus_sel[%0d]: got %0d expected %0d", j, bus_sel, srcTab[j]); end
      checks++; if (dst_en !== expEn) begin errors++; $display("FAIL stream_dst_en[%0d]: got %h expected %h", j, dst_en, expEn); end
      checks++; if (xfer_done !== 1'b1) begin errors++; $display("FAIL stream_xfer_done[%0d]: got %b expected 1", j, xfer_done); end
      checks++; if (level !== ((j < 8) ? 3'd2 : 3'(9 - j))) begin errors++; $display("FAIL stream_level[%0d]: got %0d", j, level); end
    end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_src = 5'(i + 1); cmd_dst = 5'(i + 12); cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    hold = 1'b0;
    tick();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL rmid_pre_level: got %0d expected 3", level); end
    checks++; if (dst_en !== 32'h0000_1000) begin errors++; $display("FAIL rmid_pre_dst_en: got %h expected 00001000", dst_en); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (dst_en !== 32'd0) begin errors++; $display("FAIL rmid_async_dst_en: got %h expected 0", dst_en); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rmid_async_level: got %0d expected 0", level); end
    checks++; if (xfer_done !== 1'b0) begin errors++; $display("FAIL rmid_async_xfer_done: got %b expected 0", xfer_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_async_busy: got %b expected 0", busy); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (dst_en !== 32'd0) begin errors++; $display("FAIL rmid_stale_dst_en[%0d]: got %h expected 0", i, dst_en); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL rmid_stale_level[%0d]: got %0d expected 0", i, level); end
    end
  endtask

  task automatic test_bypass();
    cmd_src = 5'd20; cmd_dst = 5'd1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++; if (bus_sel !== 5'd20) begin errors++; $display("FAIL bypass_bus_sel: got %0d expected 20", bus_sel); end
    checks++; if (dst_en !== 32'h0000_0002) begin errors++; $display("FAIL bypass_dst_en: got %h expected 00000002", dst_en); end
    checks++; if (xfer_done !== 1'b1) begin errors++; $display("FAIL bypass_xfer_done: got %b expected 1", xfer_done); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL bypass_level: got %0d expected 0", level); end
    tick();
    checks++; if (dst_en !== 32'd0) begin errors++; $display("FAIL bypass_dst_en_clear: got %h expected 0", dst_en); end
  endtask

  initial begin
    test_reset();
`ifdef BUS_XFER_BYPASS_EN
    test_bypass();
`else
    test_single();
    test_full_hold();
    test_err_src();
    test_stream();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
